// File: rtl/video_pattern_sched_pkg.sv
// Shared types and helpers for the frame-synchronous LED pattern scheduler.
// Used by vps_host_if and video_pattern_sched.
package video_pattern_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_PEND = 1'b1
  } vps_state_e;

  // Widest pattern johnson_next can advance; callers pass their real width.
  localparam int unsigned JOHNSON_MAX_W = 64;

  function automatic int unsigned clog2(input int unsigned n);
    longint unsigned p;
    int unsigned     r;
    p = 1;
    r = 0;
    while (p < longint'(n)) begin
      p = p << 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Shift left by one and feed the inverted MSB (bit w-1) into bit 0.
  function automatic logic [JOHNSON_MAX_W-1:0] johnson_next(
    input logic [JOHNSON_MAX_W-1:0] v,
    input int unsigned              w
  );
    logic [JOHNSON_MAX_W-1:0] mask;
    logic                     msb;
    mask = (JOHNSON_MAX_W'(1) << w) - JOHNSON_MAX_W'(1);
    msb  = |(v & (JOHNSON_MAX_W'(1) << (w - 1)));
    return ((v << 1) & mask) | {{(JOHNSON_MAX_W-1){1'b0}}, ~msb};
  endfunction

endpackage

// File: rtl/vps_host_if.sv
// Host side of the scheduler: REQ/ACK handshake, shadow pattern register
// and the IDLE/PEND state that holds a captured pattern until it is committed.
module vps_host_if
  import video_pattern_sched_pkg::*;
#(
  parameter int unsigned C_WIDTH = 18
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               req_i,
  input  logic [C_WIDTH-1:0] dat_i,
  input  logic               commit_req_i,
  output logic               ack_o,
  output logic               pend_o,
  output logic [C_WIDTH-1:0] shadow_o
);

  vps_state_e         state_q, state_d;
  logic [C_WIDTH-1:0] shadow_q, shadow_d;
  logic               ack_q, ack_d;

  // NOTE: every variable gets its default before the case so no path leaves it unassigned (no latch).
  always_comb begin
    state_d  = state_q;
    shadow_d = shadow_q;
    ack_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_i) begin
          state_d  = ST_PEND;
          shadow_d = dat_i;
          ack_d    = 1'b1;
        end
      end
      ST_PEND: begin
        // A request arriving here stalls unacknowledged until the commit.
        if (commit_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: the shadow is reset too, so a request interrupted by reset leaves nothing to commit later.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      shadow_q <= '0;
      ack_q    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q  <= state_d;
      shadow_q <= shadow_d;
      ack_q    <= ack_d;
    end
  end

  assign ack_o    = ack_q;
  assign pend_o   = (state_q == ST_PEND);
  assign shadow_o = shadow_q;

endmodule

// File: rtl/video_pattern_sched.sv
// Frame-synchronous scheduler for the VIDEO_SQU LED pattern: host writes vs Johnson animator,
// committed only on HVcy_i. Optional pend timeout: define VIDEO_PATTERN_SCHED_TIMEOUT_EN.
module video_pattern_sched
  import video_pattern_sched_pkg::*;
#(
  parameter int unsigned C_WIDTH     = 18,
  parameter int unsigned C_FRAME_DIV = 64,
  parameter int unsigned C_TIMEOUT   = 2_250_000
) (
  input  logic               CK_i,
  input  logic               RST_i,
  input  logic               HVcy_i,
  input  logic               AUTO_EN_i,
  input  logic               HOST_REQ_i,
  input  logic [C_WIDTH-1:0] HOST_DAT_i,
  output logic               HOST_ACK_o,
  output logic [C_WIDTH-1:0] LEDs_ON_o,
  output logic               PEND_o,
  output logic               COMMIT_o,
  output logic [5:0]         FCTRs_o,
  output logic               TOUT_o
);

  localparam int unsigned FW = (clog2(C_FRAME_DIV) > 6) ? clog2(C_FRAME_DIV) : 6;
  localparam logic [FW-1:0] FRAME_LAST = FW'(C_FRAME_DIV - 1);

  if (C_FRAME_DIV < 2 || C_TIMEOUT < 1) begin : g_param_check
    $error("video_pattern_sched: C_FRAME_DIV must be >= 2 and C_TIMEOUT >= 1");
  end

  logic               pend;
  logic [C_WIDTH-1:0] shadow;
  logic               host_commit;
  logic               auto_step;
  logic               tout_force;

  logic [FW-1:0]      fctr_q, fctr_d;
  logic [C_WIDTH-1:0] leds_q, leds_d;
  logic               commit_q, commit_d;

  vps_host_if #(
    .C_WIDTH (C_WIDTH)
  ) u_host_if (
    .clk          (CK_i),
    .rst          (RST_i),
    .req_i        (HOST_REQ_i),
    .dat_i        (HOST_DAT_i),
    .commit_req_i (host_commit),
    .ack_o        (HOST_ACK_o),
    .pend_o       (pend),
    .shadow_o     (shadow)
  );

  // Host beats animator: a colliding auto step is simply lost, the counter still wraps.
  assign host_commit = pend & (HVcy_i | tout_force);
  assign auto_step   = HVcy_i & (fctr_q == FRAME_LAST) & AUTO_EN_i;

  always_comb begin
    fctr_d   = fctr_q;
    leds_d   = leds_q;
    commit_d = 1'b0;
    if (HVcy_i) fctr_d = (fctr_q == FRAME_LAST) ? '0 : fctr_q + 1'b1;
    if (host_commit) begin
      leds_d   = shadow;
      commit_d = 1'b1;
    end else if (auto_step) begin
      leds_d   = C_WIDTH'(johnson_next(JOHNSON_MAX_W'(leds_q), C_WIDTH));
      commit_d = 1'b1;
    end
  end

  always_ff @(posedge CK_i or posedge RST_i) begin
    if (RST_i) begin
      fctr_q   <= '0;
      leds_q   <= '0;
      commit_q <= 1'b0;
    end else begin
      fctr_q   <= fctr_d;
      leds_q   <= leds_d;
      commit_q <= commit_d;
    end
  end

`ifdef VIDEO_PATTERN_SCHED_TIMEOUT_EN
  localparam int unsigned TW = clog2(C_TIMEOUT + 1);

  logic [TW-1:0] wait_q, wait_d;
  logic          tout_q, tout_d;

  // Counter idles at zero outside PEND, so it is already clear on entry.
  always_comb begin
    wait_d     = pend ? wait_q + 1'b1 : '0;
    tout_force = pend & ~HVcy_i & (wait_q == TW'(C_TIMEOUT - 1));
    tout_d     = tout_q | tout_force;
  end

  always_ff @(posedge CK_i or posedge RST_i) begin
    if (RST_i) begin
      wait_q <= '0;
      tout_q <= 1'b0;
    end else begin
      wait_q <= wait_d;
      tout_q <= tout_d;
    end
  end

  assign TOUT_o = tout_q;
`else
  assign tout_force = 1'b0;
  assign TOUT_o     = 1'b0;
`endif

  assign LEDs_ON_o = leds_q;
  assign PEND_o    = pend;
  assign COMMIT_o  = commit_q;
  assign FCTRs_o   = fctr_q[5:0];

endmodule

// File: tb/tb_video_pattern_sched.sv
// Self-checking bench for video_pattern_sched: directed scenarios plus a randomized run,
// all compared against a behavioural model of the frame/commit rules.
module tb_video_pattern_sched;

  localparam int W   = 18;
  localparam int DIV = 4;
  localparam int TMO = 100;
`ifdef VIDEO_PATTERN_SCHED_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif
  localparam logic [W-1:0] MASK = 18'h3FFFF;

  logic         ck = 1'b0;
  logic         rst = 1'b1;
  logic         hv = 1'b0;
  logic         auto_en = 1'b0;
  logic         req = 1'b0;
  logic [W-1:0] dat = '0;

  logic         ack, pend, commit, tout;
  logic [W-1:0] leds;
  logic [5:0]   fctrs;

  video_pattern_sched #(
    .C_WIDTH     (W),
    .C_FRAME_DIV (DIV),
    .C_TIMEOUT   (TMO)
  ) dut (
    .CK_i       (ck),
    .RST_i      (rst),
    .HVcy_i     (hv),
    .AUTO_EN_i  (auto_en),
    .HOST_REQ_i (req),
    .HOST_DAT_i (dat),
    .HOST_ACK_o (ack),
    .LEDs_ON_o  (leds),
    .PEND_o     (pend),
    .COMMIT_o   (commit),
    .FCTRs_o    (fctrs),
    .TOUT_o     (tout)
  );

  always #5 ck = ~ck;

  int    checks = 0;
  int    errors = 0;
  string phase  = "init";

  // Reference model: committed pattern, pending shadow, and counts of frames and PEND cycles.
  logic [W-1:0] m_leds, m_shadow;
  bit           m_pend, m_ack, m_commit, m_tout;
  int           m_hvs, m_wait;

  function automatic logic [W-1:0] jn(input logic [W-1:0] v);
    return ((v << 1) & MASK) | (v[W-1] ? 18'h0 : 18'h1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s.%s observed=%h expected=%h", phase, tag, obs, exp);
    end
  endtask

  task automatic check_all();
    chk("leds",   32'(leds),   32'(m_leds));
    chk("pend",   32'(pend),   32'(m_pend));
    chk("ack",    32'(ack),    32'(m_ack));
    chk("commit", 32'(commit), 32'(m_commit));
    chk("fctrs",  32'(fctrs),  32'(m_hvs % DIV));
    chk("tout",   32'(tout),   32'(m_tout));
  endtask

  task automatic model_reset();
    m_leds = '0; m_shadow = '0; m_pend = 0; m_ack = 0;
    m_commit = 0; m_tout = 0; m_hvs = 0; m_wait = 0;
  endtask

  // One clock cycle with the currently driven inputs; checks all outputs #1 after the edge.
  task automatic step();
    bit           to_hit, hc, au, cap, hv_now;
    logic [W-1:0] nl, dat_now;
    hv_now  = hv;
    dat_now = dat;
    to_hit  = TO_EN && m_pend && (m_wait == TMO - 1);
    hc      = m_pend && (hv_now || to_hit);
    au      = hv_now && ((m_hvs % DIV) == DIV - 1) && auto_en;
    nl      = hc ? m_shadow : (au ? jn(m_leds) : m_leds);
    cap     = !m_pend && req;
    @(posedge ck);
    #1;
    m_wait   = m_pend ? m_wait + 1 : 0;
    if (to_hit && !hv_now) m_tout = 1;
    m_leds   = nl;
    m_commit = hc || au;
    m_ack    = cap;
    if (cap) begin
      m_shadow = dat_now;
      m_pend   = 1;
    end else if (hc) begin
      m_pend = 0;
    end
    if (hv_now) m_hvs++;
    check_all();
  endtask

  task automatic frame(input int gap);
    hv = 1'b1;
    step();
    hv = 1'b0;
    repeat (gap) step();
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    req = 1'b0;
    hv  = 1'b0;
    #1;
    model_reset();
    check_all();
    @(posedge ck);
    #1;
    rst = 1'b0;
    check_all();
  endtask

  initial begin
    logic [W-1:0] r1, r2, r3;
    model_reset();

    phase = "reset";
    #1;
    check_all();
    repeat (2) @(posedge ck);
    #1;
    rst = 1'b0;
    check_all();

    // Frame counter only, animator disabled.
    phase = "count";
    for (int k = 1; k <= 10; k++) begin
      frame(2);
      chk("fctr_seq", 32'(fctrs), 32'(k % DIV));
      chk("leds_idle", 32'(leds), 32'h0);
    end

    // Animator: one step per DIV frames; 18 steps fill the register with ones.
    phase = "auto";
    pulse_reset();
    auto_en = 1'b1;
    for (int k = 1; k <= 72; k++) begin
      frame(1);
      if (k == 4)  chk("auto4",  32'(leds), 32'h00001);
      if (k == 8)  chk("auto8",  32'(leds), 32'h00003);
      if (k == 36) chk("auto36", 32'(leds), 32'h001FF);
      if (k == 72) chk("auto72", 32'(leds), 32'h3FFFF);
    end
    auto_en = 1'b0;

    phase = "host";
    req = 1'b1;
    dat = 18'h2AAAA;
    step();
    chk("ack1", 32'(ack), 32'h1);
    chk("pend1", 32'(pend), 32'h1);
    req = 1'b0;
    repeat (3) step();
    chk("leds_hold", 32'(leds), 32'h3FFFF);
    frame(0);
    chk("leds_new", 32'(leds), 32'h2AAAA);
    chk("commit1", 32'(commit), 32'h1);
    chk("pend0", 32'(pend), 32'h0);

    // Host commit collides with the auto step: host wins, auto step is dropped.
    phase = "conflict";
    pulse_reset();
    auto_en = 1'b1;
    repeat (3) frame(1);
    req = 1'b1;
    dat = 18'h2AAAA;
    step();
    req = 1'b0;
    step();
    frame(0);
    chk("host_win", 32'(leds), 32'h2AAAA);
    chk("one_commit", 32'(commit), 32'h1);
    step();
    chk("commit_drop", 32'(commit), 32'h0);
    repeat (4) frame(1);
    chk("auto_after", 32'(leds), 32'h15554);
    auto_en = 1'b0;

    phase = "stall";
    r1 = W'($urandom);
    r2 = W'($urandom);
    r3 = W'($urandom);
    req = 1'b1;
    dat = r1;
    step();
    req = 1'b0;
    step();
    req = 1'b1;
    dat = r2;
    for (int k = 0; k < 5; k++) begin
      step();
      chk("ack_stall", 32'(ack), 32'h0);
    end
    hv = 1'b1;
    step();
    hv = 1'b0;
    chk("stall_commit", 32'(leds), 32'(r1));
    chk("ack_c1", 32'(ack), 32'h0);
    step();
    chk("ack_c2", 32'(ack), 32'h1);
    req = 1'b0;
    frame(1);
    chk("stall_commit2", 32'(leds), 32'(r2));
    req = 1'b1;
    dat = r3;
    hv  = 1'b1;
    step();
    req = 1'b0;
    hv  = 1'b0;
    chk("same_cyc_pend", 32'(pend), 32'h1);
    chk("same_cyc_leds", 32'(leds), 32'(r2));
    step();
    frame(1);
    chk("same_cyc_next", 32'(leds), 32'(r3));

    phase = "midreset";
    req = 1'b1;
    dat = W'($urandom);
    step();
    req = 1'b0;
    step();
    pulse_reset();
    chk("rst_pend", 32'(pend), 32'h0);
    chk("rst_leds", 32'(leds), 32'h0);
    repeat (3) frame(2);

`ifdef VIDEO_PATTERN_SCHED_TIMEOUT_EN
    phase = "timeout";
    r1 = W'($urandom);
    req = 1'b1;
    dat = r1;
    step();
    req = 1'b0;
    repeat (TMO - 1) step();
    chk("to_pend", 32'(pend), 32'h1);
    chk("to_before", 32'(tout), 32'h0);
    step();
    chk("to_commit", 32'(commit), 32'h1);
    chk("to_leds", 32'(leds), 32'(r1));
    chk("to_flag", 32'(tout), 32'h1);
    repeat (3) frame(2);
    chk("to_sticky", 32'(tout), 32'h1);

    // HVcy on the limit cycle is an ordinary commit.
    phase = "to_edge";
    pulse_reset();
    req = 1'b1;
    dat = r1;
    step();
    req = 1'b0;
    repeat (TMO - 1) step();
    frame(1);
    chk("edge_tout", 32'(tout), 32'h0);
    chk("edge_leds", 32'(leds), 32'(r1));
`endif

    // Randomized traffic: host holds REQ until ACK, frame strobes and animator at random.
    phase = "random";
    pulse_reset();
    for (int k = 0; k < 600; k++) begin
      hv = ($urandom_range(3) == 0);
      if ($urandom_range(40) == 0) auto_en = ~auto_en;
      if (req && m_ack) req = 1'b0;
      else if (!req && $urandom_range(4) == 0) begin
        req = 1'b1;
        dat = W'($urandom);
      end
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
